sd_cmd_engine: RTL and testbench

//  Downstream consumer of the host register block. It takes the Command index
//  (Command[13:8]), the response type (Command[1:0]) and the 32-bit Argument,

---
 rtl/sd_cmd_pkg.sv | 29 ++
 rtl/sd_crc7.sv | 32 +++
 rtl/sd_cmd_engine.sv | 198 +++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared constants, FSM encoding and CRC7 step function for the SD command engine.
package sd_cmd_pkg;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_136  = 2'b01;
  localparam logic [1:0] RESP_48   = 2'b10;
  localparam logic [1:0] RESP_48B  = 2'b11;

  localparam int FRAME_LEN = 48;
  localparam int LONG_LEN  = 136;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_RECV,
    ST_DONE
  } state_e;

  // One serial CRC7 step; the feedback is the incoming bit xor the register MSB.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) accumulator; clear has priority over enable.
module sd_crc7 import sd_cmd_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 7'h00;
    end else if (en) begin
      crc_d = crc7_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command with CRC7 and captures the card response.
// Define SD_CMD_RESP_CRC_EN to check CRC7 on 48-bit responses; otherwise crc_err stays 0.
module sd_cmd_engine import sd_cmd_pkg::*; #(
  parameter int RESP_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  argument,
  input  logic [1:0]   resp_type,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         busy,
  output logic         done,
  output logic [127:0] response,
  output logic         timeout_err,
  output logic         crc_err,
  output logic         end_err,
  output logic         index_err
);

  state_e          state_q, state_d;
  logic [39:0]     tx_q, tx_d;
  logic [5:0]      tx_cnt_q, tx_cnt_d;
  logic [7:0]      rx_cnt_q, rx_cnt_d;
  logic [126:0]    rx_q, rx_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [5:0]      idx_q, idx_d;
  logic [1:0]      type_q, type_d;
  logic [127:0]    resp_q, resp_d;
  logic            to_err_q, to_err_d, crc_err_q, crc_err_d;
  logic            end_err_q, end_err_d, idx_err_q, idx_err_d;

  logic            accept, tx_crc_en, rx_crc_bad, is_long;
  logic [6:0]      tx_crc;
  logic [2:0]      crc_sel;
  logic [127:0]    rx_next;

  assign accept    = (state_q == ST_IDLE) && start;
  assign is_long   = (type_q == RESP_136);
  assign rx_next   = {rx_q, cmd_in};
  assign crc_sel   = 3'(6'd46 - tx_cnt_q);
  assign tx_crc_en = (state_q == ST_SEND) && (tx_cnt_q < 6'd40);

  sd_crc7 u_tx_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .en     (tx_crc_en),
    .bit_in (tx_q[39]),
    .crc    (tx_crc)
  );

`ifdef SD_CMD_RESP_CRC_EN
  logic       rx_crc_en;
  logic [6:0] rx_crc;
  // The start bit is the first CRC-covered bit and is seen while still in WAIT_RESP.
  assign rx_crc_en = ((state_q == ST_WAIT_RESP) && !cmd_in) ||
                     ((state_q == ST_RECV) && (rx_cnt_q < 8'd40));
  sd_crc7 u_rx_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .en     (rx_crc_en),
    .bit_in (cmd_in),
    .crc    (rx_crc)
  );
  assign rx_crc_bad = (rx_crc != rx_next[7:1]);
`else
  logic unused_rx_crc_bits;
  assign unused_rx_crc_bits = ^rx_next[7:1];
  assign rx_crc_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    rx_d      = rx_q;
    to_d      = to_q;
    idx_d     = idx_q;
    type_d    = type_q;
    resp_d    = resp_q;
    to_err_d  = to_err_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    idx_err_d = idx_err_q;
    cmd_out   = 1'b1;
    cmd_oe    = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SEND;
          tx_d      = {2'b01, cmd_index, argument};
          tx_cnt_d  = 6'd0;
          idx_d     = cmd_index;
          type_d    = resp_type;
          to_err_d  = 1'b0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
          idx_err_d = 1'b0;
        end
      end
      ST_SEND: begin
        cmd_oe   = 1'b1;
        tx_cnt_d = tx_cnt_q + 6'd1;
        if (tx_cnt_q < 6'd40) begin
          cmd_out = tx_q[39];
          tx_d    = {tx_q[38:0], 1'b0};
        end else if (tx_cnt_q < 6'd47) begin
          cmd_out = tx_crc[crc_sel];
        end
        if (tx_cnt_q == 6'(FRAME_LEN - 1)) begin
          state_d = (type_q == RESP_NONE) ? ST_DONE : ST_WAIT_RESP;
          to_d    = TO_W'(1);
        end
      end
      ST_WAIT_RESP: begin
        // to_q counts cycles since the end bit; DONE lands RESP_TIMEOUT cycles after it.
        if (!cmd_in) begin
          state_d  = ST_RECV;
          rx_d     = rx_next[126:0];
          rx_cnt_d = 8'd1;
        end else if (to_q == TO_W'(RESP_TIMEOUT - 1)) begin
          state_d  = ST_DONE;
          to_err_d = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_RECV: begin
        rx_d     = rx_next[126:0];
        rx_cnt_d = rx_cnt_q + 8'd1;
        if (rx_cnt_q == (is_long ? 8'(LONG_LEN - 1) : 8'(FRAME_LEN - 1))) begin
          state_d   = ST_DONE;
          end_err_d = ~cmd_in;
          if (is_long) begin
            resp_d = {8'h00, rx_next[127:8]};
          end else begin
            resp_d    = {96'h0, rx_next[39:8]};
            idx_err_d = (rx_next[45:40] != idx_q);
            crc_err_d = rx_crc_bad;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      rx_q      <= '0;
      to_q      <= '0;
      idx_q     <= '0;
      type_q    <= RESP_NONE;
      resp_q    <= '0;
      to_err_q  <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_q      <= rx_d;
      to_q      <= to_d;
      idx_q     <= idx_d;
      type_q    <= type_d;
      resp_q    <= resp_d;
      to_err_q  <= to_err_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
      idx_err_q <= idx_err_d;
    end
  end

  assign busy        = (state_q == ST_SEND) || (state_q == ST_WAIT_RESP) || (state_q == ST_RECV);
  assign response    = resp_q;
  assign timeout_err = to_err_q;
  assign crc_err     = crc_err_q;
  assign end_err     = end_err_q;
  assign index_err   = idx_err_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: card model, CRC by polynomial division, random traffic.
module tb_sd_cmd_engine;

  localparam int RESP_TIMEOUT = 64;

  logic         clk, reset, start, cmd_in;
  logic [5:0]   cmd_index;
  logic [31:0]  argument;
  logic [1:0]   resp_type;
  logic         cmd_out, cmd_oe, busy, done;
  logic [127:0] response;
  logic         timeout_err, crc_err, end_err, index_err;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_resp;

  sd_cmd_engine #(.RESP_TIMEOUT(RESP_TIMEOUT), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index),
    .argument(argument), .resp_type(resp_type), .cmd_in(cmd_in),
    .cmd_out(cmd_out), .cmd_oe(cmd_oe), .busy(busy), .done(done),
    .response(response), .timeout_err(timeout_err), .crc_err(crc_err),
    .end_err(end_err), .index_err(index_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1 (0x89), done as long division.
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic logic [135:0] make_r48(input logic [5:0] idx, input logic [31:0] payload);
    logic [39:0] body;
    body = {2'b00, idx, payload};
    return {88'h0, body, ref_crc7(body), 1'b1};
  endfunction

  function automatic logic [135:0] make_r136();
    logic [135:0] b;
    b = {8'h3F, $urandom(), $urandom(), $urandom(), $urandom()};
    b[0] = 1'b1;
    return b;
  endfunction

  task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input int delay, input logic [135:0] rbits,
                         input bit glitch);
    logic [47:0] frame_exp, frame_got;
    logic e_to, e_crc, e_end, e_idx;
    bit q[$];
    int len, oe_cnt, done_at, exp_done;
    bit busy_bad, oe_bad;
    frame_exp = {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
    frame_got = '0;
    len = (rt == 2'b01) ? 136 : 48;
    e_to = 0; e_crc = 0; e_end = 0; e_idx = 0;
    if (rt == 2'b00) begin
      exp_done = 1;
    end else if (delay >= RESP_TIMEOUT - 1) begin
      exp_done = RESP_TIMEOUT;
      e_to = 1;
    end else begin
      exp_done = delay + len + 1;
      for (int i = 0; i < delay; i++) q.push_back(1'b1);
      for (int i = len - 1; i >= 0; i--) q.push_back(rbits[i]);
      e_end = ~rbits[0];
      if (len == 136) begin
        exp_resp = {8'h00, rbits[127:8]};
      end else begin
        exp_resp = {96'h0, rbits[39:8]};
        e_idx = (rbits[45:40] != idx);
`ifdef SD_CMD_RESP_CRC_EN
        e_crc = (ref_crc7(rbits[47:8]) != rbits[7:1]);
`endif
      end
    end

    cmd_index = idx; argument = arg; resp_type = rt; cmd_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    oe_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      frame_got = {frame_got[46:0], cmd_out};
      if (cmd_oe === 1'b1) oe_cnt++;
      if (glitch && i == 10) begin
        start = 1'b1; cmd_index = ~idx; argument = ~arg; resp_type = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;

    checks++;
    if (frame_got !== frame_exp) begin
      errors++; $display("FAIL %s frame: got %h expected %h", name, frame_got, frame_exp);
    end
    checks++;
    if (oe_cnt !== 48) begin
      errors++; $display("FAIL %s oe_cycles: got %0d expected 48", name, oe_cnt);
    end
    checks++;
    if (cmd_oe !== 1'b0 || cmd_out !== 1'b1) begin
      errors++; $display("FAIL %s line_release: got oe=%b out=%b expected oe=0 out=1", name, cmd_oe, cmd_out);
    end

    done_at = -1; busy_bad = 0; oe_bad = 0;
    for (int n = 1; n <= 300; n++) begin
      cmd_in = (q.size() > 0) ? q.pop_front() : 1'b1;
      if (cmd_oe !== 1'b0) oe_bad = 1;
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1;
      tick();
    end

    checks++;
    if (done_at !== exp_done) begin
      errors++; $display("FAIL %s done_latency: got %0d expected %0d", name, done_at, exp_done);
    end
    checks++;
    if (busy !== 1'b0 || busy_bad || oe_bad) begin
      errors++; $display("FAIL %s busy_oe_wait: got busy@done=%b busy_drop=%b oe_drive=%b expected 0 0 0", name, busy, busy_bad, oe_bad);
    end
    checks++;
    if (response !== exp_resp) begin
      errors++; $display("FAIL %s response: got %h expected %h", name, response, exp_resp);
    end
    checks++;
    if ({timeout_err, crc_err, end_err, index_err} !== {e_to, e_crc, e_end, e_idx}) begin
      errors++; $display("FAIL %s flags(to,crc,end,idx): got %b%b%b%b expected %b%b%b%b", name,
                         timeout_err, crc_err, end_err, index_err, e_to, e_crc, e_end, e_idx);
    end

    if (glitch) begin
      start = 1'b1; cmd_index = 6'($urandom); resp_type = 2'($urandom);
    end
    tick();
    start = 1'b0;
    cmd_in = 1'b1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
    $display("txn %s: cmd=%0d arg=%h type=%0d done_at=%0d resp=%h", name, idx, arg, rt, done_at, response);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cmd_in = 1'b1;
    cmd_index = '0; argument = '0; resp_type = 2'b00;
    repeat (3) tick();
    checks++;
    if ({cmd_out, cmd_oe, busy, done} !== 4'b1000 || response !== 128'h0 ||
        {timeout_err, crc_err, end_err, index_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_state: got out/oe/busy/done=%b%b%b%b resp=%h flags=%b%b%b%b expected 1000 0 0000",
                         cmd_out, cmd_oe, busy, done, response, timeout_err, crc_err, end_err, index_err);
    end
    reset = 1'b0;
    exp_resp = '0;
    tick();
    $display("txn reset: released");
  endtask

  task automatic test_cmd0();
    checks++;
    if ({2'b01, 6'd0, 32'h0, ref_crc7({2'b01, 6'd0, 32'h0}), 1'b1} !== 48'h40_00000000_95) begin
      errors++; $display("FAIL cmd0_model_crc: got %h expected 95", {ref_crc7({2'b01, 6'd0, 32'h0}), 1'b1});
    end
    run_cmd("cmd0", 6'd0, 32'h0, 2'b00, 0, '0, 1'b1);
  endtask

  task automatic test_cmd8();
    logic [135:0] r;
    r = make_r48(6'd8, 32'h000001AA);
    checks++;
    if (r[47:0] !== 48'h08_000001AA_13) begin
      errors++; $display("FAIL cmd8_model_resp: got %h expected 08000001aa13", r[47:0]);
    end
    run_cmd("cmd8", 6'd8, 32'h000001AA, 2'b10, 5, r, 1'b0);
  endtask

  task automatic test_timeout();
    run_cmd("cmd17_timeout", 6'd17, 32'h0, 2'b10, 1000, '0, 1'b0);
    run_cmd("edge_delay62", 6'd13, 32'h12345678, 2'b11, RESP_TIMEOUT - 2, make_r48(6'd13, 32'hCAFEF00D), 1'b0);
    run_cmd("edge_delay63", 6'd13, 32'h12345678, 2'b10, RESP_TIMEOUT - 1, make_r48(6'd13, 32'h0BADBEEF), 1'b0);
  endtask

  task automatic test_resp_errors();
    logic [135:0] r;
    run_cmd("bad_index", 6'd8, 32'h000001AA, 2'b10, 3, make_r48(6'd9, 32'h000001AA), 1'b0);
    r = make_r48(6'd8, 32'h000001AA);
    r[0] = 1'b0;
    run_cmd("bad_end", 6'd8, 32'h000001AA, 2'b10, 2, r, 1'b0);
    r = make_r48(6'd8, 32'h000001AA);
    r[3] = ~r[3];
    run_cmd("bad_crc", 6'd8, 32'h000001AA, 2'b10, 0, r, 1'b0);
  endtask

  task automatic test_long();
    run_cmd("cmd2_r2", 6'd2, 32'h0, 2'b01, 4, make_r136(), 1'b1);
  endtask

  task automatic test_reset_mid();
    cmd_index = 6'd17; argument = $urandom; resp_type = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    checks++;
    if (cmd_oe !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: got oe=%b busy=%b expected 1 1", cmd_oe, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({cmd_oe, busy, cmd_out, done} !== 4'b0010 || response !== 128'h0) begin
      errors++; $display("FAIL reset_mid: got oe/busy/out/done=%b%b%b%b resp=%h expected 0010 0",
                         cmd_oe, busy, cmd_out, done, response);
    end
    reset = 1'b0;
    exp_resp = '0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle: got busy=%b expected 0", busy);
    end
    $display("txn reset_mid: aborted at bit 20");
    run_cmd("after_reset", 6'd55, 32'h89ABCDEF, 2'b10, 1, make_r48(6'd55, 32'h13572468), 1'b0);
  endtask

  task automatic test_random();
    logic [135:0] r;
    logic [5:0]   idx;
    logic [1:0]   rt;
    int           dly, k;
    for (int it = 0; it < 12; it++) begin
      idx = 6'($urandom);
      rt  = 2'($urandom);
      dly = (it % 4 == 3) ? $urandom_range(60, 70) : $urandom_range(0, 10);
      k   = $urandom_range(0, 3);
      if (rt == 2'b01) begin
        r = make_r136();
        if (k == 2) r[0] = 1'b0;
      end else begin
        r = make_r48((k == 1) ? (idx ^ 6'($urandom_range(1, 63))) : idx, $urandom);
        if (k == 2) r[0] = 1'b0;
        if (k == 3) r[$urandom_range(1, 7)] ^= 1'b1;
      end
      run_cmd($sformatf("rand%0d", it), idx, $urandom, rt, dly, r, bit'(it % 2));
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_timeout();
    test_resp_errors();
    test_long();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
